// File: rtl/uart_tx_fifo.sv
// UART transmitter with a circular transmit FIFO, runtime baud divisor,
// optional even/odd parity and one or two stop bits. Frames are sent back-to-back.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              uart_tx,
  output logic              busy,
  output logic              tx_done,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              push, pop, empty, full;
  logic [DATA_W-1:0] head;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = wr_valid && !full;
  assign head  = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d, eff_div;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              stop_q, stop_d, two_q, two_d;
  logic              par_en_q, par_en_d, par_bit_q, par_bit_d;
  logic              tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic              tick, start_frame;

  assign eff_div = (baud_div > DIV_W'(1)) ? baud_div : DIV_W'(1);
  assign tick    = (cnt_q == div_q - DIV_W'(1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    stop_d      = stop_q;
    two_d       = two_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    start_frame = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d        = 1'b1;
        busy_d      = 1'b0;
        cnt_d       = '0;
        start_frame = !empty;
      end
      START: begin
        if (tick) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d = '0;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (two_q && !stop_q) begin
            stop_d = 1'b1;
          end else if (!empty) begin
            start_frame = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Frame start is shared by IDLE and a STOP end with data pending: the
    // start bit goes out on the pop edge, so no idle gap appears between frames.
    if (start_frame) begin
      state_d   = START;
      cnt_d     = '0;
      shreg_d   = head;
      div_d     = eff_div;
      two_d     = two_stop;
      par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_bit_d = (^head) ^ (parity_mode == 2'b10);
      tx_d      = 1'b0;
      busy_d    = 1'b1;
    end
    pop    = start_frame;
    // Registered pulse lands on the final clk cycle of the last stop bit.
    done_d = (state_d == STOP) && (stop_d == two_d) && (cnt_d == div_d - DIV_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= DIV_W'(1);
      bit_q     <= '0;
      shreg_q   <= '0;
      stop_q    <= 1'b0;
      two_q     <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      stop_q    <= stop_d;
      two_q     <= two_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wr_ready   = !full;
  assign uart_tx    = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;
  assign fifo_count = count_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with a built-in transmit FIFO, runtime baud divisor, selectable parity and one or two stop bits. It is the successor to the fixed 8N1, single-byte transmitter. The CPU-side store path writes words through a valid/ready handshake. The block serialises them back-to-back onto the tx line, LSB first, with no idle gap while the FIFO is non-empty.

Parameters:
DATA_W, 8, data bits per frame; legal 5..9.
FIFO_DEPTH, 16, FIFO entries; power of two, minimum 2.
DIV_W, 16, width of the baud divisor port.
CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count (derived; do not override).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
baud_div  in  DIV_W  clk cycles per bit; values 0 and 1 are treated as 1.
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none.
two_stop  in  1  0 = one stop bit, 1 = two stop bits.
wr_data  in  DATA_W  word to send.
wr_valid  in  1  write request.
wr_ready  out  1  !full; a write is accepted when wr_valid && wr_ready at a clk edge.
uart_tx  out  1  serial line, idle high.
busy  out  1  high from the start-bit edge until the last stop bit ends, with no further frame pending.
tx_done  out  1  one-cycle pulse at the end of every frame.
fifo_count  out  CNT_W  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (clk edge with rst=1):
  - uart_tx=1, busy=0, tx_done=0.
  - FIFO flushed: count 0, wr_ready=1.
  - FSM in IDLE; baud counter 0.
  - Applies mid-frame: the line returns high on that edge and the partial frame is abandoned.
- FIFO:
  - Circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits, wrapping at FIFO_DEPTH.
  - Push and pop on the same edge leave the count unchanged.
  - A write while full is ignored; wr_ready=0 in that case.
  - A pop never happens while empty.
  - The count updates on the edge of the handshake.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - uart_tx=1, busy=0.
  - If the FIFO is non-empty at an edge: pop the head word, and latch it together with baud_div, parity_mode and two_stop.
  - On that same edge drive uart_tx=0, set busy=1, enter START.
  - A write into an empty, idle block therefore drives uart_tx low on the edge after the write edge.
  - Config inputs changing mid-frame have no effect until the next frame.
- Bit timing:
  - Each bit is held for exactly max(baud_div,1) clk cycles.
  - The baud counter counts 0..div-1; at div-1 it resets and the FSM advances.
- START: 1 bit period of 0, then DATA with bit index 0.
- DATA:
  - Transmits latched bits [0..DATA_W-1], LSB first.
  - After bit DATA_W-1: go to PARITY if the latched mode is 01 or 10, else STOP.
- PARITY:
  - Even mode sends XOR of the data bits.
  - Odd mode sends its inverse.
- STOP:
  - 1 or 2 bit periods of 1, per the latched two_stop.
  - At the end: tx_done pulses for one cycle.
  - If the FIFO is non-empty: pop, drive the start bit on the same edge, stay busy=1.
  - Otherwise: go to IDLE, busy=0.
- Frame length = (1 + DATA_W + P + S) × div cycles, where P∈{0,1} and S∈{1,2}.
- A write on the same edge a frame pops the last entry is accepted normally and becomes the next frame.

Test Plan:
1. Reset, then baud_div=4, parity 00, two_stop=0, write 0xA5 → uart_tx = 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop), each bit for 4 cycles; busy for 40 cycles; one tx_done pulse; line then idle high.
2. Same byte 0xA5 with parity 01 → parity bit 0; with parity 10 → parity bit 1; each frame is 44 cycles. With two_stop=1 → the stop level lasts 8 cycles.
3. FIFO_DEPTH=4, baud_div=2: write 6 words on consecutive cycles → wr_ready drops after 5 accepted (one popped immediately, 4 buffered) and the sixth is held; all words are sent back-to-back with no idle cycle; fifo_count decrements at each frame start; busy stays high across all frames.
4. Assert rst mid-DATA of a frame with 3 words queued → next edge: uart_tx=1, busy=0, fifo_count=0, wr_ready=1; no further frames are sent.
5. Change baud_div 4→8 and parity in the middle of frame 1 of 2 → frame 1 completes at div 4 with the old parity; frame 2 uses div 8 and the new parity.
6. baud_div=0 and DATA_W=5, write 0x15 → 7-cycle frame 0,1,0,1,0,1,1; tx_done pulses on the last cycle.
